alu_serial_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit ALU slice (ALU_1_BIT): accepts a WIDTH-bit op via valid/ready,

---
 rtl/alu_pkg.sv | 27 ++
 rtl/serial_shift_reg.sv | 40 ++++
 rtl/alu_serial_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer and its bench.
package alu_pkg;

    // Full 4-bit op words: {Ainvert, Binvert, logic field}
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // Logic field, op[1:0]
    localparam logic [1:0] LOGIC_AND     = 2'b00;
    localparam logic [1:0] LOGIC_OR      = 2'b01;
    localparam logic [1:0] LOGIC_ADD     = 2'b10;
    localparam logic [1:0] LOGIC_ILLEGAL = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when the op uses the carry chain (ADD/SUB family)
    function automatic logic is_add_class(input logic [3:0] op);
        return op[1:0] == LOGIC_ADD;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register with parallel load; the serial input enters at the MSB.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load wins over shift; otherwise hold
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_val;
        end else if (shift) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
        end
    end

    // State register, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign par_out = data_q;
    assign ser_out = data_q[0];

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, LSB first, with a registered carry chain.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_carryin,
    output logic [3:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_carryout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_illegal
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             running;
    logic             a_ser, b_ser;
    logic [WIDTH-1:0] a_word, b_word, res_word;
    logic             res_ser;
    logic             unused_bits;

    assign accept  = in_valid && (state_q == ST_IDLE);
    assign running = (state_q == ST_RUN);

    // Operands are consumed only through their serial outputs
    assign unused_bits = ^{a_word, b_word, res_ser};

    serial_shift_reg #(.WIDTH(WIDTH)) u_a_reg (
        .clk(clk), .reset(reset), .load(accept), .load_val(in_a),
        .shift(running), .ser_in(1'b0), .par_out(a_word), .ser_out(a_ser)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b_reg (
        .clk(clk), .reset(reset), .load(accept), .load_val(in_b),
        .shift(running), .ser_in(1'b0), .par_out(b_word), .ser_out(b_ser)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_res_reg (
        .clk(clk), .reset(reset), .load(accept), .load_val('0),
        .shift(running), .ser_in(slice_result), .par_out(res_word), .ser_out(res_ser)
    );

    // Sequencer, carry chain and flag capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_d     = '0;
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    zero_d    = 1'b0;
                    illegal_d = (in_op[1:0] == LOGIC_ILLEGAL);
                    carry_d   = is_add_class(in_op) ? in_op[2] : 1'b0;
                    if (in_op[1:0] == LOGIC_ILLEGAL) begin
                        op_d    = 4'b0000;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        op_d    = in_op;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_add_class(op_q)) begin
                    carry_d = slice_carryout;
                end
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    cout_d  = is_add_class(op_q) && slice_carryout;
                    ovf_d   = is_add_class(op_q) && (carry_q ^ slice_carryout);
                    zero_d  = ({slice_result, res_word[WIDTH-1:1]} == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and flag registers; reset discards any partial operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= 4'b0000;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign slice_a       = running && a_ser;
    assign slice_b       = running && b_ser;
    assign slice_carryin = running && carry_q;
    assign slice_op      = running ? op_q : 4'b0000;
    assign out_result    = res_word;
    assign out_carry     = cout_q;
    assign out_ovf       = ovf_q;
    assign out_zero      = zero_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench: behavioural 1-bit slice on the slice_* ports, word-level reference model.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [3:0]       in_op = 4'b0000;
    logic             slice_a, slice_b, slice_carryin;
    logic [3:0]       slice_op;
    logic             slice_result, slice_carryout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             out_carry, out_ovf, out_zero, out_illegal;

    int checkCount = 0;
    int passCount  = 0;
    int illegalDriveCount = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .slice_a(slice_a), .slice_b(slice_b), .slice_carryin(slice_carryin),
        .slice_op(slice_op), .slice_result(slice_result), .slice_carryout(slice_carryout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_illegal(out_illegal)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Behavioural ALU_1_BIT slice: optional input inversion, then AND / OR / full-add
    logic sa, sb;
    always_comb begin
        sa = slice_a ^ slice_op[3];
        sb = slice_b ^ slice_op[2];
        slice_result = 1'b0;
        case (slice_op[1:0])
            2'b00:   slice_result = sa & sb;
            2'b01:   slice_result = sa | sb;
            2'b10:   slice_result = sa ^ sb ^ slice_carryin;
            default: slice_result = 1'b0;
        endcase
        slice_carryout = (sa & sb) | (sa & slice_carryin) | (sb & slice_carryin);
    end

    // The slice must never be handed the illegal logic field
    always @(posedge clk) begin
        if (slice_op[1:0] == 2'b11) illegalDriveCount <= illegalDriveCount + 1;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Word-level reference: two's-complement arithmetic on the (optionally inverted) operands
    task automatic refModel(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                            output logic [7:0] res, output logic c, output logic v,
                            output logic z, output logic ill);
        logic [7:0] ae, be;
        logic [8:0] sum;
        ae = op[3] ? ~a : a;
        be = op[2] ? ~b : b;
        res = 8'h00; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op[1:0])
            2'b00: res = ae & be;
            2'b01: res = ae | be;
            2'b10: begin
                sum = {1'b0, ae} + {1'b0, be} + {8'h00, op[2]};
                res = sum[7:0];
                c   = sum[8];
                v   = (ae[7] == be[7]) && (res[7] != ae[7]);
            end
            default: ill = 1'b1;
        endcase
        z = (res == 8'h00);
    endtask

    // One full transaction: accept, wait for result, compare, optionally stall the consumer, release
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                 input int holdCycles, input bit earlyReady);
        logic [7:0] expRes;
        logic expC, expV, expZ, expIll;
        int k, expLat, wait_n;
        refModel(a, b, op, expRes, expC, expV, expZ, expIll);
        expLat = expIll ? 1 : WIDTH + 1;
        @(negedge clk);
        wait_n = 0;
        while (!in_ready && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        checkOutput("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = earlyReady;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_op    = 4'($urandom_range(0, 15));
        checkOutput("busy_in_ready", in_ready, 0);
        k = 1;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("latency", k, expLat);
        checkOutput("result", out_result, expRes);
        checkOutput("carry", out_carry, expC);
        checkOutput("ovf", out_ovf, expV);
        checkOutput("zero", out_zero, expZ);
        checkOutput("illegal", out_illegal, expIll);
        if (!earlyReady) begin
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_in_ready", in_ready, 0);
                checkOutput("hold_result", out_result, expRes);
                checkOutput("hold_flags", {out_carry, out_ovf, out_zero, out_illegal},
                            {expC, expV, expZ, expIll});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release_valid", out_valid, 0);
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("idle_slice_op", slice_op, 0);
    endtask

    // Main sequence: reset checks, directed cases, mid-run reset, random cases
    initial begin
        logic [7:0] ra, rb, runA;
        logic [3:0] rop;
        $display("[TB] start");
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", out_result, 0);
        checkOutput("rst_slice_op", slice_op, 0);
        reset = 1'b0;

        applyStimulus(8'h5A, 8'h3C, OP_ADD, 0, 1'b0);
        applyStimulus(8'h10, 8'h20, OP_SUB, 0, 1'b0);
        applyStimulus(8'h42, 8'h42, OP_SUB, 0, 1'b0);
        applyStimulus(8'hF0, 8'h3C, OP_AND, 5, 1'b0);
        applyStimulus(8'hF0, 8'h0F, OP_OR,  0, 1'b0);
        applyStimulus(8'hF0, 8'h3C, OP_NOR, 0, 1'b0);
        applyStimulus(8'h12, 8'h34, 4'b0011, 2, 1'b0);

        // Reset while the sequencer is on bit 3 of an add
        runA = 8'h77;
        @(negedge clk);
        in_valid = 1'b1; in_a = runA; in_b = 8'h11; in_op = OP_ADD;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("run_slice_op", slice_op, OP_ADD);
        checkOutput("run_slice_a", slice_a, runA[3]);
        reset = 1'b1;
        #1;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_result", out_result, 0);
        checkOutput("midrst_flags", {out_carry, out_ovf, out_zero, out_illegal}, 0);
        checkOutput("midrst_slice", {slice_a, slice_b, slice_carryin, slice_op}, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h01, 8'h01, OP_ADD, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            applyStimulus(ra, rb, rop, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        checkOutput("slice_never_op11", illegalDriveCount, 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
